// File: rtl/saa_psg_n.sv
// saa_psg_n: bus-programmed square-wave/noise generator with a serial channel
// mixer that normalises the summed levels to a full-scale OUT_W-bit stereo sample.
module saa_psg_n #(
  parameter int CHANNELS = 6,
  parameter int OUT_W    = 10
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             cs_n,
  input  logic             a0,
  input  logic             wr_n,
  input  logic [7:0]       din,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic             sample_valid
);

  localparam int SUM_W  = 4 + $clog2(CHANNELS + 1);
  localparam int PROD_W = SUM_W + 16 + OUT_W;
  localparam int K_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [63:0] GAIN_WIDE =
    (((64'd1 << OUT_W) - 64'd1) << 16) / (64'd15 * 64'(CHANNELS));
  localparam logic [PROD_W-1:0] GAIN = GAIN_WIDE[PROD_W-1:0];
  localparam logic [16:0] LFSR_SEED = 17'h00001;

  typedef enum logic [1:0] {IDLE, SCAN, SCALE} state_t;

  function automatic logic [3:0] level(input logic [3:0] amp4, input logic tone_en,
                                       input logic noise_en, input logic tone,
                                       input logic noise);
    logic [3:0] lvl;
    lvl = '0;
    if (tone_en && noise_en) begin
      if (tone && !noise)     lvl = amp4;
      else if (tone && noise) lvl = amp4 >> 1;
    end else if (tone_en) begin
      if (tone) lvl = amp4;
    end else if (noise_en) begin
      if (noise) lvl = amp4;
    end
    return lvl;
  endfunction

  // Bus write detect: one write per falling edge of wr_n while selected.
  logic       wr_n_prev_reg;
  logic [5:0] addr_reg;
  logic       wr_stb;
  logic       data_wr;
  logic [1:0] noise_rate_reg;
  logic [1:0] ctrl_reg;
  logic       gen_rst;
  logic       sound_en;

  assign wr_stb  = ~cs_n & ~wr_n & wr_n_prev_reg;
  assign data_wr = wr_stb & ~a0;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_n_prev_reg  <= 1'b0;
      addr_reg       <= '0;
      noise_rate_reg <= '0;
      ctrl_reg       <= '0;
    end else begin
      wr_n_prev_reg <= wr_n;
      if (wr_stb && a0) addr_reg <= din[5:0];
      if (data_wr) begin
        case (addr_reg)
          6'h34:   noise_rate_reg <= din[1:0];
          6'h3C:   ctrl_reg       <= din[1:0];
          default: ;
        endcase
      end
    end
  end

  // A ctrl write setting bit1 already holds the generators in its own cycle.
  assign gen_rst  = ctrl_reg[1] | (data_wr && (addr_reg == 6'h3C) && din[1]);
  assign sound_en = ctrl_reg[0];

  logic [3:0]  lvl_l [CHANNELS];
  logic [3:0]  lvl_r [CHANNELS];
  logic        ch0_tpulse;
  logic        noise;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [5:0] TEN_ADDR = 6'(48 + gi / 8);
    localparam logic [5:0] NEN_ADDR = 6'(50 + gi / 8);
    localparam int         EN_BIT   = gi % 8;

    logic [7:0]  amp_reg;
    logic [7:0]  freq_reg;
    logic [2:0]  oct_reg;
    logic        tone_en_reg;
    logic        noise_en_reg;
    logic [16:0] cnt_reg;
    logic        tone_reg;
    logic [16:0] reload;

    assign reload = ({8'd0, 9'd511 - {1'b0, freq_reg}} << (4'd8 - {1'b0, oct_reg})) - 17'd1;

    always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
        amp_reg      <= '0;
        freq_reg     <= '0;
        oct_reg      <= '0;
        tone_en_reg  <= 1'b0;
        noise_en_reg <= 1'b0;
      end else if (data_wr) begin
        if (addr_reg == 6'(gi))      amp_reg      <= din;
        if (addr_reg == 6'(16 + gi)) freq_reg     <= din;
        if (addr_reg == 6'(32 + gi)) oct_reg      <= din[2:0];
        if (addr_reg == TEN_ADDR)    tone_en_reg  <= din[EN_BIT];
        if (addr_reg == NEN_ADDR)    noise_en_reg <= din[EN_BIT];
      end
    end

    // freq/oct are sampled only at reload, so a new pitch starts on the next period.
    always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg  <= '0;
        tone_reg <= 1'b0;
      end else if (gen_rst) begin
        cnt_reg  <= reload;
        tone_reg <= 1'b0;
      end else if (ce) begin
        if (cnt_reg == 17'd0) begin
          cnt_reg  <= reload;
          tone_reg <= ~tone_reg;
        end else begin
          cnt_reg <= cnt_reg - 17'd1;
        end
      end
    end

    if (gi == 0) begin : g_tp
      assign ch0_tpulse = ce & ~gen_rst & (cnt_reg == 17'd0);
    end

    assign lvl_l[gi] = level(amp_reg[3:0], tone_en_reg, noise_en_reg, tone_reg, noise);
    assign lvl_r[gi] = level(amp_reg[7:4], tone_en_reg, noise_en_reg, tone_reg, noise);
  end

  // Noise: 17-bit LFSR clocked by a prescaler or by channel 0 reloads.
  logic [16:0] lfsr_reg;
  logic [16:0] lfsr_shift;
  logic [16:0] lfsr_step;
  logic [10:0] ncnt_reg;
  logic [10:0] noise_lim;

  assign lfsr_shift = {lfsr_reg[0] ^ lfsr_reg[3], lfsr_reg[16:1]};
  assign lfsr_step  = (lfsr_shift == 17'd0) ? LFSR_SEED : lfsr_shift;
  assign noise_lim  = (11'd256 << noise_rate_reg) - 11'd1;
  assign noise      = lfsr_reg[0];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
      ncnt_reg <= '0;
    end else if (gen_rst) begin
      lfsr_reg <= LFSR_SEED;
      ncnt_reg <= '0;
    end else if (ce) begin
      if (noise_rate_reg == 2'd3) begin
        ncnt_reg <= '0;
        if (ch0_tpulse) lfsr_reg <= lfsr_step;
      end else if (ncnt_reg >= noise_lim) begin
        ncnt_reg <= '0;
        lfsr_reg <= lfsr_step;
      end else begin
        ncnt_reg <= ncnt_reg + 11'd1;
      end
    end
  end

  // Serial mixer: one channel per cycle through a shared adder, then one scale cycle.
  state_t             state_reg, state_next;
  logic [K_W-1:0]     k_reg;
  logic [SUM_W-1:0]   sum_l_reg, sum_r_reg;
  logic [PROD_W-1:0]  prod_l, prod_r;

  assign prod_l = PROD_W'(sum_l_reg) * GAIN;
  assign prod_r = PROD_W'(sum_r_reg) * GAIN;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ce) state_next = SCAN;
      SCAN:    if (k_reg == K_W'(CHANNELS - 1)) state_next = SCALE;
      SCALE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      k_reg        <= '0;
      sum_l_reg    <= '0;
      sum_r_reg    <= '0;
      out_l        <= '0;
      out_r        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ce) begin
            k_reg     <= '0;
            sum_l_reg <= '0;
            sum_r_reg <= '0;
          end
        end
        SCAN: begin
          sum_l_reg <= sum_l_reg + SUM_W'(lvl_l[k_reg]);
          sum_r_reg <= sum_r_reg + SUM_W'(lvl_r[k_reg]);
          k_reg     <= k_reg + 1'b1;
        end
        SCALE: begin
          out_l        <= sound_en ? OUT_W'(prod_l >> 16) : '0;
          out_r        <= sound_en ? OUT_W'(prod_r >> 16) : '0;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_saa_psg_n.sv
// Bench for saa_psg_n: table-driven level vectors plus tone/noise/reset sequences,
// with every expected sample queued at its ce and compared when sample_valid fires.
`timescale 1ns/1ps
module tb_saa_psg_n;
  localparam int CH = 6;
  localparam int OW = 10;

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b1;
  logic          ce      = 1'b0;
  logic          cs_n    = 1'b1;
  logic          a0      = 1'b0;
  logic          wr_n    = 1'b1;
  logic [7:0]    din     = 8'h00;
  logic [OW-1:0] out_l;
  logic [OW-1:0] out_r;
  logic          sample_valid;

  saa_psg_n #(.CHANNELS(CH), .OUT_W(OW)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .ce           (ce),
    .cs_n         (cs_n),
    .a0           (a0),
    .wr_n         (wr_n),
    .din          (din),
    .out_l        (out_l),
    .out_r        (out_r),
    .sample_valid (sample_valid)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] l;
    logic [OW-1:0] r;
    int            ce_cyc;
    string         tag;
  } exp_t;

  typedef struct {
    logic [7:0]    amp;
    logic          ten;
    logic          nen;
    logic          snd;
    logic [OW-1:0] el;
    logic [OW-1:0] er;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every sample_valid pulse must match the oldest queued sample.
  always @(negedge clk_sys) begin
    exp_t e;
    if (sample_valid === 1'b1) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: sample_valid at cycle %0d with no sample pending", cyc);
      end else begin
        e = sb_q.pop_front();
        $display("sample %s cyc=%0d out_l=%0d/%0d out_r=%0d/%0d", e.tag, cyc, out_l, e.l, out_r, e.r);
        check({e.tag, "_l"}, 32'(out_l), 32'(e.l));
        check({e.tag, "_r"}, 32'(out_r), 32'(e.r));
        check({e.tag, "_latency"}, 32'(cyc - e.ce_cyc), 32'(CH + 2));
      end
    end
  end

  task automatic wr_bus(input logic is_addr, input logic [7:0] d);
    @(negedge clk_sys);
    cs_n = 1'b0; a0 = is_addr; din = d; wr_n = 1'b0;
    @(negedge clk_sys);
    wr_n = 1'b1; cs_n = 1'b1;
  endtask

  task automatic wr_reg(input logic [5:0] ad, input logic [7:0] d);
    wr_bus(1'b1, {2'b00, ad});
    wr_bus(1'b0, d);
  endtask

  task automatic pulse_ce(input logic expect_sample, input logic [OW-1:0] el,
                          input logic [OW-1:0] er, input string tag);
    exp_t e;
    @(negedge clk_sys);
    ce = 1'b1;
    if (expect_sample) begin
      e.l = el; e.r = er; e.ce_cyc = cyc; e.tag = tag;
      sb_q.push_back(e);
    end
    @(negedge clk_sys);
    ce = 1'b0;
  endtask

  task automatic settle();
    repeat (CH + 3) @(negedge clk_sys);
  endtask

  function automatic logic [16:0] lfsr_next(input logic [16:0] s);
    logic [16:0] n;
    n = {s[0] ^ s[3], s[16:1]};
    if (n == 17'd0) n = 17'h00001;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [9];
    logic        tone_m;
    logic        tp;
    logic [16:0] lfsr_m;
    int          p0;

    // Right after reset all tones toggle high on the first ce and noise sits at the seed.
    vt[0] = '{8'h0F, 1'b1, 1'b0, 1'b1, 10'd170, 10'd0};
    vt[1] = '{8'hF0, 1'b1, 1'b0, 1'b1, 10'd0,   10'd170};
    vt[2] = '{8'h8C, 1'b1, 1'b0, 1'b1, 10'd136, 10'd90};
    vt[3] = '{8'h0F, 1'b0, 1'b1, 1'b1, 10'd170, 10'd0};
    vt[4] = '{8'h0F, 1'b1, 1'b1, 1'b1, 10'd79,  10'd0};
    vt[5] = '{8'h53, 1'b1, 1'b1, 1'b1, 10'd11,  10'd22};
    vt[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 10'd0,   10'd0};
    vt[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 10'd0,   10'd0};
    vt[8] = '{8'h61, 1'b1, 1'b0, 1'b1, 10'd11,  10'd68};

    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_out_l", 32'(out_l), 32'd0);
    check("reset_out_r", 32'(out_r), 32'd0);
    check("reset_valid", 32'(sample_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int i = 0; i < 9; i++) begin
      wr_reg(6'h00, vt[i].amp);
      wr_reg(6'h30, {7'd0, vt[i].ten});
      wr_reg(6'h32, {7'd0, vt[i].nen});
      wr_reg(6'h3C, {7'd0, vt[i].snd});
      pulse_ce(1'b1, vt[i].el, vt[i].er, $sformatf("vec%0d", i));
      settle();
    end
    check("vec_pending", 32'(sb_q.size()), 32'd0);

    // Bus protocol: a long wr_n-low strobe writes once; a deselected strobe does nothing.
    wr_reg(6'h30, 8'h01);
    wr_reg(6'h32, 8'h00);
    wr_reg(6'h3C, 8'h01);
    wr_bus(1'b1, 8'h00);
    @(negedge clk_sys);
    cs_n = 1'b0; a0 = 1'b0; din = 8'h0F; wr_n = 1'b0;
    @(negedge clk_sys);
    din = 8'h00;
    repeat (4) @(negedge clk_sys);
    wr_n = 1'b1; cs_n = 1'b1;
    pulse_ce(1'b1, 10'd170, 10'd0, "hold5");
    settle();
    @(negedge clk_sys);
    cs_n = 1'b1; a0 = 1'b0; din = 8'hF0; wr_n = 1'b0;
    @(negedge clk_sys);
    wr_n = 1'b1;
    pulse_ce(1'b1, 10'd170, 10'd0, "csn_high");
    settle();

    // Full scale on every channel, then sound enable off and back on.
    for (int c = 0; c < CH; c++) wr_reg(6'(c), 8'hFF);
    wr_reg(6'h30, 8'h3F);
    pulse_ce(1'b1, 10'd1022, 10'd1022, "full");
    settle();
    wr_reg(6'h3C, 8'h00);
    pulse_ce(1'b1, 10'd0, 10'd0, "snd_off");
    settle();
    wr_reg(6'h3C, 8'h01);
    pulse_ce(1'b1, 10'd1022, 10'd1022, "snd_on");
    settle();
    check("full_pending", 32'(sb_q.size()), 32'd0);

    // Reset asserted mid-scan: outputs clear and the dropped sample never appears.
    p0 = n_pulses;
    pulse_ce(1'b0, 10'd0, 10'd0, "none");
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    check("midscan_rst_out_l", 32'(out_l), 32'd0);
    check("midscan_rst_out_r", 32'(out_r), 32'd0);
    check("midscan_rst_valid", 32'(sample_valid), 32'd0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("midscan_no_pulse", 32'(n_pulses - p0), 32'd0);
    wr_reg(6'h00, 8'h0F);
    wr_reg(6'h30, 8'h01);
    wr_reg(6'h3C, 8'h01);
    pulse_ce(1'b1, 10'd170, 10'd0, "post_rst");
    settle();

    // Generator reset held: ch0 tone (L) stays low, ch1 noise (R) stays on the seed.
    wr_reg(6'h10, 8'hFF);
    wr_reg(6'h20, 8'h07);
    wr_reg(6'h01, 8'hF0);
    wr_reg(6'h32, 8'h02);
    wr_reg(6'h34, 8'h00);
    wr_reg(6'h3C, 8'h03);
    for (int i = 0; i < 100; i++) begin
      pulse_ce(1'b1, 10'd0, 10'd170, "genrst");
      settle();
    end
    wr_reg(6'h3C, 8'h01);

    // Released: P=512 first toggle at ce 512; freq 0x7F from ce 701 gives P=768 after
    // the reload at 1024. Noise steps every 256 ce, then on ch0 reloads from ce 1201.
    tone_m = 1'b0;
    lfsr_m = 17'h00001;
    for (int n = 1; n <= 1900; n++) begin
      if (n == 701)  wr_reg(6'h10, 8'h7F);
      if (n == 1201) wr_reg(6'h34, 8'h03);
      tp = (n == 512) || (n == 1024) || (n == 1792);
      if (tp) tone_m = ~tone_m;
      if ((n <= 1200) ? (n % 256 == 0) : tp) lfsr_m = lfsr_next(lfsr_m);
      pulse_ce(1'b1, tone_m ? 10'd170 : 10'd0, lfsr_m[0] ? 10'd170 : 10'd0,
               $sformatf("tn%0d", n));
      settle();
    end

    check("final_pending", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
